wb_stream_writer_ring: RTL and testbench
========================================

// Module: wb_stream_writer_ring
// PURPOSE
//  Wishbone-B3 burst-reading DMA feeding a valid/ready stream via internal FWFT FIFO. Generalises wb_stream_writer:
//  parametrised data width, any word-multiple buffer size (short final burst), circular mode, bus-error abort.
//  Sits between system memory (wbm_*) and a streaming sink; configured by CPU over wbs_*.
// PARAMETERS
//  DW            32  data width (bits, multiple of 8); WSB=DW/8 bytes per word
//  AW            32  Wishbone address width
//  FIFO_AW       5   FIFO depth = 2**FIFO_AW words
//  MAX_BURST_LEN 32  max beats per burst; must be <= 2**FIFO_AW
// PORTS
//  clk               in  1      clock
//  rst_n             in  1      async active-low reset
//  wbm_adr_o         out AW     burst address; wbm_dat_o out DW, constant 0
//  wbm_sel_o out DW/8 all ones; wbm_we_o out 1, 0; wbm_cyc_o/wbm_stb_o out 1; wbm_cti_o out 3; wbm_bte_o out 2, 00
//  wbm_dat_i in DW; wbm_ack_i/wbm_err_i/wbm_rty_i in 1  master read response
//  stream_m_data_o   out DW     FIFO head word
//  stream_m_valid_o  out 1      FIFO not empty
//  stream_m_ready_i  in  1      sink accepts
//  stream_m_irq_o    out 1      level interrupt
//  wbs_adr_i in AW; wbs_dat_i in 32; wbs_sel_i in 4; wbs_we_i/cyc/stb in 1; wbs_cti_i in 3; wbs_bte_i in 2
//  wbs_dat_o out 32; wbs_ack_o/wbs_err_o/wbs_rty_o out 1  config slave
// BEHAVIOUR
//  Reset: all wbm_*/wbs_* outputs 0 (sel all ones), valid 0, irq 0, FIFO empty, regs 0, FSM IDLE.
//  FSM: IDLE -enable-> LOAD (latch shadow regs, addr=START_ADDR, rem=BUF_SIZE/WSB) -> WAIT_SPACE ->
//   BURST (cyc=stb=1) -> WAIT_SPACE if rem>0, else DRAIN; DRAIN -last word accepted on stream-> irq=1,
//   then LOAD if circular && enable else IDLE (enable cleared).
//  Burst length L=min(BURST_SIZE,rem). BURST entered only when FIFO free >= L (no overflow ever).
//  cti=010 on beats 1..L-1, 111 on final beat (L=1: single 111). Each ack: push wbm_dat_i, adr+=WSB, rem-=1.
//  rty: treated as wait (beat not counted, stb held). err: drop beat, end cycle next clk, CSR.err=1,
//   irq=1, enable=0, IDLE; FIFO contents still drain to stream.
//  Enable cleared mid-burst: current burst completes, then IDLE; FIFO drains. rem/addr discarded.
//  BUF_SIZE low log2(WSB) bits ignored; BUF_SIZE<WSB: LOAD->DRAIN (empty FIFO) -> irq next cycle.
//  BURST_SIZE 0 treated as 1; >MAX_BURST_LEN clamped to MAX_BURST_LEN.
//  Stream: data stable while valid&&!ready; push+pop same cycle allowed at any fill level.
//  Slave: ack 1-cycle pulse cycle after cyc&stb&!ack, read data registered; err/rty tied 0.
// CONFIGURATION (byte offsets, adr[4:0])
//  0x00 CSR: b0 enable RW; b1 irq clear W1C (reads irq); b2 circular RW; b3 busy RO; b4 err RO (cleared by b1 write)
//  0x04 START_ADDR; 0x08 BUF_SIZE bytes; 0x0C BURST_SIZE words; 0x10 WORD_COUNT RO (words sent this pass)
//  START/BUF/BURST writes while busy take effect at next LOAD. irq clear and new irq same cycle: irq stays 1.
//  Optional macro WB_STREAM_WRITER_RING_LAST_EN: adds stream_m_last_o out 1, high with final word of each
//   buffer pass (reset 0); FIFO widened to DW+1. Undefined: port absent, FIFO DW wide.
// TESTING
//  START=0x40, BUF=96, BURST=8, ready=1 -> bursts 8,8,8 beats, cti 010x7 then 111, 24 words match mem, irq.
//  BUF=40, BURST=8 -> bursts 8,2; 2-beat burst cti 010,111; 10 words; WORD_COUNT=10 then irq.
//  Circular, BUF=32, BURST=4, 3 passes -> addresses wrap to START each pass; irq per pass after W1C clear.
//  err injected on beat 3 of burst 2 -> cyc drops, CSR.err=1, irq=1, exactly 4+2 words reach stream.
//  ready toggled 10% duty, FIFO_AW=3, BURST=8 -> no burst starts with free<8; no lost/duplicated words.
//  rst_n pulsed low mid-burst -> cyc/stb/valid/irq 0 immediately; new config after reset runs cleanly.

Source files
------------

// File: rtl/wb_stream_writer_ring.sv
// wb_stream_writer_ring: Wishbone burst-read DMA into a FWFT FIFO feeding a valid/ready stream (optional macro WB_STREAM_WRITER_RING_LAST_EN adds stream_m_last_o)
module wb_stream_writer_ring #(
  parameter int DW = 32,
  parameter int AW = 32,
  parameter int FIFO_AW = 5,
  parameter int MAX_BURST_LEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic [AW-1:0]   wbm_adr_o,
  output logic [DW-1:0]   wbm_dat_o,
  output logic [DW/8-1:0] wbm_sel_o,
  output logic            wbm_we_o,
  output logic            wbm_cyc_o,
  output logic            wbm_stb_o,
  output logic [2:0]      wbm_cti_o,
  output logic [1:0]      wbm_bte_o,
  input  logic [DW-1:0]   wbm_dat_i,
  input  logic            wbm_ack_i,
  input  logic            wbm_err_i,
  input  logic            wbm_rty_i,
  output logic [DW-1:0]   stream_m_data_o,
  output logic            stream_m_valid_o,
  input  logic            stream_m_ready_i,
`ifdef WB_STREAM_WRITER_RING_LAST_EN
  output logic            stream_m_last_o,
`endif
  output logic            stream_m_irq_o,
  input  logic [AW-1:0]   wbs_adr_i,
  input  logic [31:0]     wbs_dat_i,
  input  logic [3:0]      wbs_sel_i,
  input  logic            wbs_we_i,
  input  logic            wbs_cyc_i,
  input  logic            wbs_stb_i,
  input  logic [2:0]      wbs_cti_i,
  input  logic [1:0]      wbs_bte_i,
  output logic [31:0]     wbs_dat_o,
  output logic            wbs_ack_o,
  output logic            wbs_err_o,
  output logic            wbs_rty_o
);
  localparam int WSB = DW / 8;
  localparam int LSB = $clog2(WSB);
  localparam int DEPTH = 1 << FIFO_AW;
`ifdef WB_STREAM_WRITER_RING_LAST_EN
  localparam int FW = DW + 1;
`else
  localparam int FW = DW;
`endif
  typedef enum logic [2:0] {IDLE, LOAD, WAIT_SPACE, BURST, DRAIN} state_t;
  state_t state;
  logic enable, circular, irq, err, cyc;
  logic [31:0] start_addr, buf_size, burst_size, word_count;
  logic [AW-1:0] addr;
  logic [31:0] rem, bsz, beats, free, blen, bclamp, rdata;
  logic [FW-1:0] mem [DEPTH];
  logic [FW-1:0] head, push_word;
  logic [FIFO_AW:0] wr_ptr, rd_ptr, count;
  logic push, pop, req, cfg_wr, unused;
  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] sel);
    for (int i = 0; i < 4; i++) merge[8*i +: 8] = sel[i] ? d[8*i +: 8] : old[8*i +: 8];
  endfunction
  assign wbm_adr_o = addr;
  assign wbm_dat_o = '0;
  assign wbm_sel_o = '1;
  assign wbm_we_o = 1'b0;
  assign wbm_bte_o = 2'b00;
  assign wbm_cyc_o = cyc;
  assign wbm_stb_o = cyc;
  assign wbs_err_o = 1'b0;
  assign wbs_rty_o = 1'b0;
  assign stream_m_irq_o = irq;
  assign unused = ^{wbs_cti_i, wbs_bte_i, wbm_rty_i, wbs_adr_i};
  assign count = wr_ptr - rd_ptr;
  assign free = 32'(DEPTH) - 32'(count);
  assign stream_m_valid_o = count != '0;
  assign pop = stream_m_valid_o && stream_m_ready_i;
  assign push = state == BURST && cyc && wbm_ack_i && !wbm_err_i;
  assign head = mem[rd_ptr[FIFO_AW-1:0]];
  assign stream_m_data_o = head[DW-1:0];
`ifdef WB_STREAM_WRITER_RING_LAST_EN
  assign stream_m_last_o = stream_m_valid_o && head[DW];
  assign push_word = {rem == 32'd1, wbm_dat_i};
`else
  assign push_word = wbm_dat_i;
`endif
  assign blen = rem < bsz ? rem : bsz;
  assign bclamp = burst_size == 32'd0 ? 32'd1 : burst_size > 32'(MAX_BURST_LEN) ? 32'(MAX_BURST_LEN) : burst_size;
  assign req = wbs_cyc_i && wbs_stb_i && !wbs_ack_o;
  assign cfg_wr = req && wbs_we_i;
  assign rdata = wbs_adr_i[4:2] == 3'd0 ? {27'd0, err, state != IDLE, circular, irq, enable} :
                 wbs_adr_i[4:2] == 3'd1 ? start_addr :
                 wbs_adr_i[4:2] == 3'd2 ? buf_size :
                 wbs_adr_i[4:2] == 3'd3 ? burst_size :
                 wbs_adr_i[4:2] == 3'd4 ? word_count : 32'd0;
  // FIFO storage, written on every accepted read beat; the array itself needs no reset
  always_ff @(posedge clk)
    if (push) mem[wr_ptr[FIFO_AW-1:0]] <= push_word;
  // FIFO pointers; push and pop may coincide at any fill level
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
    end
  // Config slave: one-cycle ack pulse with registered read data
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
    end else begin
      wbs_ack_o <= req;
      if (req) wbs_dat_o <= rdata;
    end
  // Register file and DMA sequencer; sequencer events override same-cycle CPU writes
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      enable <= 1'b0;
      circular <= 1'b0;
      irq <= 1'b0;
      err <= 1'b0;
      start_addr <= '0;
      buf_size <= '0;
      burst_size <= '0;
      word_count <= '0;
      addr <= '0;
      rem <= '0;
      bsz <= '0;
      beats <= '0;
      cyc <= 1'b0;
      wbm_cti_o <= 3'b000;
    end else begin
      if (cfg_wr && wbs_adr_i[4:2] == 3'd0 && wbs_sel_i[0]) begin
        enable <= wbs_dat_i[0];
        circular <= wbs_dat_i[2];
        if (wbs_dat_i[1]) begin
          irq <= 1'b0;
          err <= 1'b0;
        end
      end
      if (cfg_wr && wbs_adr_i[4:2] == 3'd1) start_addr <= merge(start_addr, wbs_dat_i, wbs_sel_i);
      if (cfg_wr && wbs_adr_i[4:2] == 3'd2) buf_size <= merge(buf_size, wbs_dat_i, wbs_sel_i);
      if (cfg_wr && wbs_adr_i[4:2] == 3'd3) burst_size <= merge(burst_size, wbs_dat_i, wbs_sel_i);
      if (pop) word_count <= word_count + 32'd1;
      case (state)
        IDLE: if (enable) state <= LOAD;
        LOAD: begin
          addr <= AW'(start_addr);
          rem <= buf_size >> LSB;
          bsz <= bclamp;
          word_count <= '0;
          state <= (buf_size >> LSB) == 32'd0 ? DRAIN : WAIT_SPACE;
        end
        WAIT_SPACE: begin
          if (!enable) state <= IDLE;
          else if (free >= blen) begin
            cyc <= 1'b1;
            beats <= blen;
            wbm_cti_o <= blen == 32'd1 ? 3'b111 : 3'b010;
            state <= BURST;
          end
        end
        BURST: begin
          if (wbm_err_i) begin
            cyc <= 1'b0;
            wbm_cti_o <= 3'b000;
            err <= 1'b1;
            irq <= 1'b1;
            enable <= 1'b0;
            state <= IDLE;
          end else if (wbm_ack_i) begin
            addr <= addr + AW'(WSB);
            rem <= rem - 32'd1;
            beats <= beats - 32'd1;
            if (beats == 32'd1) begin
              cyc <= 1'b0;
              wbm_cti_o <= 3'b000;
              state <= rem == 32'd1 ? DRAIN : enable ? WAIT_SPACE : IDLE;
            end else if (beats == 32'd2) wbm_cti_o <= 3'b111;
          end
        end
        DRAIN: begin
          if (!stream_m_valid_o) begin
            irq <= 1'b1;
            if (circular && enable) state <= LOAD;
            else begin
              enable <= 1'b0;
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_wb_stream_writer_ring.sv
// tb_wb_stream_writer_ring: randomized scoreboard bench with a memory model and a per-pass transfer plan
module tb_wb_stream_writer_ring;
  localparam int DEPTH = 8;
  localparam int MBL = 8;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [31:0] wbm_adr_o, wbm_dat_o, stream_m_data_o, wbs_dat_o;
  logic [31:0] wbm_dat_i = '0;
  logic [31:0] wbs_adr_i = '0;
  logic [31:0] wbs_dat_i = '0;
  logic [3:0] wbm_sel_o;
  logic [3:0] wbs_sel_i = 4'hf;
  logic wbm_we_o, wbm_cyc_o, wbm_stb_o, stream_m_valid_o, stream_m_irq_o, wbs_ack_o, wbs_err_o, wbs_rty_o;
  logic wbm_ack_i = 1'b0;
  logic wbm_err_i = 1'b0;
  logic wbm_rty_i = 1'b0;
  logic stream_m_ready_i = 1'b0;
  logic wbs_we_i = 1'b0;
  logic wbs_cyc_i = 1'b0;
  logic wbs_stb_i = 1'b0;
  logic [2:0] wbm_cti_o;
  logic [2:0] wbs_cti_i = 3'b000;
  logic [1:0] wbm_bte_o;
  logic [1:0] wbs_bte_i = 2'b00;
`ifdef WB_STREAM_WRITER_RING_LAST_EN
  logic stream_m_last_o;
`endif
  typedef struct {
    logic [31:0] adr;
    logic [2:0] cti;
    bit first;
    int len;
  } beat_t;
  logic [31:0] mem [1024];
  beat_t bus_q[$];
  logic [31:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int rdy_pct = 100;
  int rty_pct = 0;
  int wait_pct = 0;
  int err_at = -1;
  int acks = 0;
  int occ = 0;
  bit prev_cyc = 0;
  bit popped_last = 0;
  always #5 clk = ~clk;
  wb_stream_writer_ring #(.DW(32), .AW(32), .FIFO_AW(3), .MAX_BURST_LEN(MBL)) dut (
    .clk(clk), .rst_n(rst_n),
    .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_sel_o(wbm_sel_o), .wbm_we_o(wbm_we_o),
    .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_cti_o(wbm_cti_o), .wbm_bte_o(wbm_bte_o),
    .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack_i), .wbm_err_i(wbm_err_i), .wbm_rty_i(wbm_rty_i),
    .stream_m_data_o(stream_m_data_o), .stream_m_valid_o(stream_m_valid_o), .stream_m_ready_i(stream_m_ready_i),
`ifdef WB_STREAM_WRITER_RING_LAST_EN
    .stream_m_last_o(stream_m_last_o),
`endif
    .stream_m_irq_o(stream_m_irq_o),
    .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i), .wbs_sel_i(wbs_sel_i), .wbs_we_i(wbs_we_i),
    .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i), .wbs_cti_i(wbs_cti_i), .wbs_bte_i(wbs_bte_i),
    .wbs_dat_o(wbs_dat_o), .wbs_ack_o(wbs_ack_o), .wbs_err_o(wbs_err_o), .wbs_rty_o(wbs_rty_o)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask
  // Expected beats and words of one buffer pass, from the transfer rules alone
  task automatic plan(input logic [31:0] start, input int bufsz, input int bs, input int err_beat);
    int rem;
    int b;
    int l;
    int n;
    logic [31:0] a;
    rem = bufsz / 4;
    b = bs == 0 ? 1 : (bs > MBL ? MBL : bs);
    a = start;
    n = 0;
    while (rem > 0) begin
      l = rem < b ? rem : b;
      for (int i = 0; i < l; i++) begin
        if (err_beat >= 0 && n > err_beat) return;
        bus_q.push_back('{a, (i == l - 1) ? 3'b111 : 3'b010, i == 0, l});
        if (n != err_beat) exp_q.push_back(mem[a[11:2]]);
        a += 4;
        n++;
      end
      rem -= l;
    end
  endtask
  // Memory slave responses plus stream and bus monitors
  always @(negedge clk) begin
    int r;
    beat_t bt;
    if (!rst_n) begin
      wbm_ack_i = 0;
      wbm_err_i = 0;
      wbm_rty_i = 0;
      stream_m_ready_i = 0;
      prev_cyc = 0;
      popped_last = 0;
      occ = 0;
    end else begin
      if (wbm_cyc_o && !prev_cyc && bus_q.size() != 0) begin
        chk("burst_free", 32'((DEPTH - occ - int'(popped_last)) >= bus_q[0].len), 1);
        chk("burst_first", 32'(bus_q[0].first), 1);
      end
      prev_cyc = wbm_cyc_o;
      stream_m_ready_i = ($urandom_range(99) < rdy_pct);
      popped_last = stream_m_valid_o && stream_m_ready_i;
      if (popped_last) begin
        occ--;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL stream_extra actual=%h required=none", stream_m_data_o);
        end else begin
          checks--;
          chk("stream_data", stream_m_data_o, exp_q.pop_front());
        end
      end
      wbm_ack_i = 0;
      wbm_err_i = 0;
      wbm_rty_i = 0;
      if (wbm_cyc_o && wbm_stb_o) begin
        r = $urandom_range(99);
        if (acks != err_at && r < rty_pct) wbm_rty_i = 1;
        else if (acks != err_at && r < rty_pct + wait_pct) wbm_ack_i = 0;
        else if (bus_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL bus_extra actual=%h required=none", wbm_adr_o);
        end else begin
          bt = bus_q.pop_front();
          chk("beat_adr", wbm_adr_o, bt.adr);
          if (acks == err_at) begin
            wbm_err_i = 1;
            err_at = -1;
          end else begin
            chk("beat_cti", 32'(wbm_cti_o), 32'(bt.cti));
            wbm_ack_i = 1;
            wbm_dat_i = mem[wbm_adr_o[11:2]];
            acks++;
            occ++;
          end
        end
      end
    end
  end
  task automatic wb_xfer(input logic we, input logic [4:0] a, input logic [31:0] wd, output logic [31:0] rd);
    int n;
    n = 0;
    @(posedge clk);
    #1;
    wbs_adr_i = {27'd0, a};
    wbs_dat_i = wd;
    wbs_we_i = we;
    wbs_sel_i = 4'hf;
    wbs_cyc_i = 1;
    wbs_stb_i = 1;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!wbs_ack_o && n < 8);
    chk("wb_ack", 32'(wbs_ack_o), 1);
    rd = wbs_dat_o;
    wbs_cyc_i = 0;
    wbs_stb_i = 0;
    wbs_we_i = 0;
  endtask
  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    logic [31:0] junk;
    wb_xfer(1'b1, a, d, junk);
  endtask
  task automatic rd_chk(input string name, input logic [4:0] a, input logic [31:0] exp);
    logic [31:0] d;
    wb_xfer(1'b0, a, 32'd0, d);
    chk(name, d, exp);
  endtask
  task automatic start_pass(input logic [31:0] s, input int b, input int bs, input int e, input int passes,
                            input int rdy, input int rty, input int wt, input logic [31:0] csr);
    wr(5'h04, s);
    wr(5'h08, 32'(b));
    wr(5'h0c, 32'(bs));
    rdy_pct = rdy;
    rty_pct = rty;
    wait_pct = wt;
    acks = 0;
    err_at = e;
    for (int p = 0; p < passes; p++) plan(s, b, bs, e);
    wr(5'h00, csr);
  endtask
  task automatic wait_irq(input string name, input int budget);
    int n;
    n = 0;
    while (!stream_m_irq_o && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk(name, 32'(stream_m_irq_o), 1);
  endtask
  task automatic wait_drain(input string name, input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || bus_q.size() != 0 || stream_m_valid_o) && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({name, "_words_left"}, 32'(exp_q.size()), 0);
    chk({name, "_beats_left"}, 32'(bus_q.size()), 0);
  endtask
  initial begin
    int n;
    for (int i = 0; i < 1024; i++) mem[i] = $urandom;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cyc", 32'(wbm_cyc_o), 0);
    chk("rst_valid", 32'(stream_m_valid_o), 0);
    chk("rst_sel", 32'(wbm_sel_o), 32'hf);
    rst_n = 1;
    chk("rst_irq", 32'(stream_m_irq_o), 0);
    chk("rst_wbs_ack", 32'(wbs_ack_o), 0);
    for (int i = 0; i < 5; i++) rd_chk("rst_reg", 5'(4 * i), 32'd0);
    start_pass(32'h40, 96, 8, -1, 1, 100, 0, 0, 32'h1);
    wait_irq("t1_irq", 2000);
    wait_drain("t1", 2000);
    rd_chk("t1_csr", 5'h00, 32'h2);
    rd_chk("t1_count", 5'h10, 32'd24);
    wr(5'h00, 32'h2);
    rd_chk("t1_clr", 5'h00, 32'h0);
    start_pass(32'h140, 40, 8, -1, 1, 70, 10, 10, 32'h1);
    wait_irq("t2_irq", 2000);
    wait_drain("t2", 2000);
    rd_chk("t2_count", 5'h10, 32'd10);
    wr(5'h00, 32'h2);
    start_pass(32'h100, 32, 4, -1, 3, 50, 10, 10, 32'h5);
    wait_irq("circ_irq1", 3000);
    wr(5'h00, 32'h7);
    rd_chk("circ_clr1", 5'h00, 32'hd);
    wait_irq("circ_irq2", 3000);
    wr(5'h00, 32'h3);
    rd_chk("circ_clr2", 5'h00, 32'h9);
    wait_irq("circ_irq3", 3000);
    wait_drain("circ", 3000);
    rd_chk("circ_csr", 5'h00, 32'h2);
    wr(5'h00, 32'h2);
    start_pass(32'h200, 64, 4, 6, 1, 100, 0, 20, 32'h1);
    wait_irq("err_irq", 2000);
    wait_drain("err", 2000);
    rd_chk("err_csr", 5'h00, 32'h12);
    rd_chk("err_count", 5'h10, 32'd6);
    chk("err_cyc", 32'(wbm_cyc_o), 0);
    wr(5'h00, 32'h2);
    rd_chk("err_clr", 5'h00, 32'h0);
    start_pass(32'h300, 200, 8, -1, 1, 10, 5, 10, 32'h1);
    wait_irq("slow_irq", 8000);
    wait_drain("slow", 2000);
    rd_chk("slow_count", 5'h10, 32'd50);
    wr(5'h00, 32'h2);
    start_pass(32'h40, 3, 8, -1, 1, 100, 0, 0, 32'h1);
    wait_irq("tiny_irq", 6);
    rd_chk("tiny_count", 5'h10, 32'd0);
    wr(5'h00, 32'h2);
    start_pass(32'h80, 12, 0, -1, 1, 100, 0, 0, 32'h1);
    wait_irq("b0_irq", 1000);
    wait_drain("b0", 1000);
    wr(5'h00, 32'h2);
    start_pass(32'h180, 83, 100, -1, 1, 80, 0, 10, 32'h1);
    wait_irq("bclamp_irq", 2000);
    wait_drain("bclamp", 1000);
    rd_chk("bclamp_count", 5'h10, 32'd20);
    wr(5'h00, 32'h2);
    start_pass(32'h80, 400, 8, -1, 1, 30, 0, 0, 32'h1);
    n = 0;
    while (!wbm_cyc_o && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("mid_cyc_seen", 32'(wbm_cyc_o), 1);
    rst_n = 0;
    #1;
    chk("mid_rst_cyc", 32'(wbm_cyc_o), 0);
    chk("mid_rst_stb", 32'(wbm_stb_o), 0);
    chk("mid_rst_valid", 32'(stream_m_valid_o), 0);
    chk("mid_rst_irq", 32'(stream_m_irq_o), 0);
    bus_q.delete();
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
    rd_chk("post_rst_csr", 5'h00, 32'h0);
    rd_chk("post_rst_start", 5'h04, 32'h0);
    start_pass(32'h20, 24, 4, -1, 1, 60, 10, 10, 32'h1);
    wait_irq("post_irq", 2000);
    wait_drain("post", 2000);
    rd_chk("post_csr", 5'h00, 32'h2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
  initial begin
    #900000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end
endmodule
